sensor_scan_uc: RTL and testbench

- Parametrised control unit for the multi-sensor measure-and-report loop.
- Sequences N_SENS distance-sensor channels through one measurement each, then transmits BYTES_POR_MEDIDA serial bytes per channel.
- Waits a programmable interval between rounds. Supports single-round and continuous modes, with a per-channel measurement timeout.
- Sits between the game top level (jogar/parar) and the sensor-interface and serial-TX datapath.

---
 rtl/roberto_pkg.sv | 31 +++
 rtl/sensor_scan_uc_contador.sv | 44 ++++
 rtl/sensor_scan_uc.sv | 157 +++++++++++++++
 tb/tb_sensor_scan_uc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/roberto_pkg.sv
`default_nettype none
// ============================================================================
// Module      : roberto_pkg
// Description : Shared state encoding and clock-derived timing constants for
//               the sensor scan control unit and its debug display decoder.
// Revision    : 1.0
// ============================================================================
package roberto_pkg;

    localparam int CLK_FREQ_HZ      = 50_000_000;
    localparam int INTERVALO_PADRAO = CLK_FREQ_HZ;               // 1 s between rounds
    localparam int TIMEOUT_PADRAO   = (CLK_FREQ_HZ / 1000) * 30; // 30 ms per echo

    // Codes double as the 7-segment debug digit, so values are fixed.
    typedef enum logic [3:0] {
        INICIAL           = 4'd0,
        MEDIR             = 4'd1,
        AGUARDA_MEDIDA    = 4'd2,
        TRANSMITE         = 4'd3,
        AGUARDA_TX        = 4'd4,
        PROX_SENS         = 4'd5,
        AGUARDA_INTERVALO = 4'd6,
        FINAL             = 4'd7
    } estado_t;

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_scan_uc_contador.sv
`default_nettype none
// ============================================================================
// Module      : contador_m
// Description : Modulo-M up counter with synchronous clear; fim flags M-1.
// Revision    : 1.0
// ============================================================================
module contador_m
    import roberto_pkg::*;
#(
    parameter  int M = 16,
    localparam int W = max1($clog2(M))
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (zera) begin
            cnt_d = '0;
        end else if (conta) begin
            cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim = (cnt_q == ULTIMO);

endmodule
`default_nettype wire

// File: rtl/sensor_scan_uc.sv
`default_nettype none
// ============================================================================
// Module      : sensor_scan_uc
// Description : Control unit sequencing N_SENS sensor measurements and their
//               serial reports, in single-round or continuous mode.
// Revision    : 1.0
// ============================================================================
module sensor_scan_uc
    import roberto_pkg::*;
#(
    parameter  int N_SENS           = 3,
    parameter  int BYTES_POR_MEDIDA = 4,
    parameter  int INTERVALO_CICLOS = INTERVALO_PADRAO,
    parameter  int TIMEOUT_CICLOS   = TIMEOUT_PADRAO,
    localparam int SENS_W           = max1($clog2(N_SENS)),
    localparam int BYTE_W           = max1($clog2(BYTES_POR_MEDIDA))
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              jogar,
    input  logic              continuo,
    input  logic              parar,
    input  logic [N_SENS-1:0] pronto_medida,
    input  logic              pronto_tx,
    output logic              medir,
    output logic [SENS_W-1:0] sel_sens,
    output logic              partida_tx,
    output logic [BYTE_W-1:0] sel_byte,
    output logic              zera_sensor,
    output logic              ocupado,
    output logic              fim,
    output logic [N_SENS-1:0] erro_timeout,
    output logic [3:0]        db_estado
);

    localparam logic [SENS_W-1:0] SENS_ULT = SENS_W'(N_SENS - 1);
    localparam logic [BYTE_W-1:0] BYTE_ULT = BYTE_W'(BYTES_POR_MEDIDA - 1);

    estado_t           estado_q, estado_d;
    logic [SENS_W-1:0] sens_q, sens_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [N_SENS-1:0] erro_q, erro_d;
    logic              cont_q, cont_d;
    logic              parar_q, parar_d;
    logic              fim_timeout, fim_intervalo;

    contador_m #(.M(TIMEOUT_CICLOS)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (estado_q == MEDIR),
        .conta (estado_q == AGUARDA_MEDIDA),
        .fim   (fim_timeout)
    );

    contador_m #(.M(INTERVALO_CICLOS)) u_intervalo (
        .clock (clock),
        .reset (reset),
        .zera  (estado_q == PROX_SENS),
        .conta (estado_q == AGUARDA_INTERVALO),
        .fim   (fim_intervalo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
            sens_q   <= '0;
            byte_q   <= '0;
            erro_q   <= '0;
            cont_q   <= 1'b0;
            parar_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            sens_q   <= sens_d;
            byte_q   <= byte_d;
            erro_q   <= erro_d;
            cont_q   <= cont_d;
            parar_q  <= parar_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        sens_d   = sens_q;
        byte_d   = byte_q;
        erro_d   = erro_q;
        cont_d   = cont_q;
        parar_d  = parar_q | (parar && (estado_q != INICIAL));

        case (estado_q)
            INICIAL: begin
                if (jogar) begin
                    cont_d   = continuo;
                    erro_d   = '0;
                    sens_d   = '0;
                    estado_d = MEDIR;
                end
            end
            MEDIR: estado_d = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: begin
                // A valid echo on the last timeout cycle still gets reported.
                if (pronto_medida[sens_q]) begin
                    byte_d   = '0;
                    estado_d = TRANSMITE;
                end else if (fim_timeout) begin
                    erro_d[sens_q] = 1'b1;
                    estado_d       = PROX_SENS;
                end
            end
            TRANSMITE: estado_d = AGUARDA_TX;
            AGUARDA_TX: begin
                if (pronto_tx) begin
                    if (byte_q == BYTE_ULT) begin
                        estado_d = PROX_SENS;
                    end else begin
                        byte_d   = byte_q + 1'b1;
                        estado_d = TRANSMITE;
                    end
                end
            end
            PROX_SENS: begin
                if (sens_q == SENS_ULT) begin
                    estado_d = (!cont_q || parar_q) ? FINAL : AGUARDA_INTERVALO;
                end else begin
                    sens_d   = sens_q + 1'b1;
                    estado_d = MEDIR;
                end
            end
            AGUARDA_INTERVALO: begin
                if (parar || parar_q) begin
                    estado_d = FINAL;
                end else if (fim_intervalo) begin
                    sens_d   = '0;
                    erro_d   = '0;
                    estado_d = MEDIR;
                end
            end
            FINAL: begin
                parar_d  = 1'b0;
                estado_d = INICIAL;
            end
            default: estado_d = INICIAL;
        endcase
    end

    assign medir        = (estado_q == MEDIR);
    assign partida_tx   = (estado_q == TRANSMITE);
    assign fim          = (estado_q == FINAL);
    assign ocupado      = (estado_q != INICIAL);
    // Gated by reset so the datapath sees no clear strobe while held in reset.
    assign zera_sensor  = reset && (estado_q == INICIAL);
    assign sel_sens     = sens_q;
    assign sel_byte     = byte_q;
    assign erro_timeout = erro_q;
    assign db_estado    = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_scan_uc.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_scan_uc
// Description : Table-driven and directed self-checking bench for sensor_scan_uc.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sensor_scan_uc;

    localparam int N  = 3;
    localparam int B  = 2;
    localparam int IV = 20;
    localparam int TO = 10;

    logic       clock = 1'b0, reset = 1'b1, jogar = 1'b0, continuo = 1'b0, parar = 1'b0;
    logic       pronto_tx = 1'b0;
    logic [2:0] pm_resp = '0, pm_extra = '0, pronto_medida;
    logic       medir, partida_tx, zera_sensor, ocupado, fim;
    logic [1:0] sel_sens;
    logic [0:0] sel_byte;
    logic [2:0] erro_timeout;
    logic [3:0] db_estado;

    assign pronto_medida = pm_resp | pm_extra;

    sensor_scan_uc #(
        .N_SENS(N), .BYTES_POR_MEDIDA(B), .INTERVALO_CICLOS(IV), .TIMEOUT_CICLOS(TO)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .continuo(continuo), .parar(parar),
        .pronto_medida(pronto_medida), .pronto_tx(pronto_tx), .medir(medir),
        .sel_sens(sel_sens), .partida_tx(partida_tx), .sel_byte(sel_byte),
        .zera_sensor(zera_sensor), .ocupado(ocupado), .fim(fim),
        .erro_timeout(erro_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Sensor/TX responder: echoes medir after med_delay cycles, partida_tx after 5.
    logic [2:0] silent    = '0;
    int         med_delay = 3;
    int         med_cd = 0, tx_cd = 0, med_ch = 0;
    int         medir_cnt = 0, tx_cnt = 0, fim_cnt = 0;
    int         med_log[$];
    int         tx_log[$];

    initial begin
        forever begin
            @(negedge clock);
            pm_resp   = '0;
            pronto_tx = 1'b0;
            if (med_cd > 0) begin
                med_cd--;
                if (med_cd == 0 && !silent[med_ch]) pm_resp[med_ch] = 1'b1;
            end
            if (tx_cd > 0) begin
                tx_cd--;
                if (tx_cd == 0) pronto_tx = 1'b1;
            end
            if (medir === 1'b1) begin
                medir_cnt++;
                med_log.push_back(int'(sel_sens));
                med_cd = med_delay;
                med_ch = int'(sel_sens);
            end
            if (partida_tx === 1'b1) begin
                tx_cnt++;
                tx_log.push_back(int'(sel_sens) * 16 + int'(sel_byte));
                tx_cd = 5;
            end
            if (fim === 1'b1) fim_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_estado(input logic [3:0] s, input string name);
        int n = 0;
        while (db_estado !== s && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (db_estado !== s) begin
            checks++;
            errors++;
            $display("FAIL %s: state %0d not reached, stuck at %0d", name, s, db_estado);
        end
    endtask

    task automatic wait_fim(input string name);
        int n = 0;
        while (fim !== 1'b1 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (fim !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: no fim within %0d cycles", name, n);
        end
    endtask

    task automatic pulse_jogar();
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
    endtask

    typedef struct {
        logic [2:0] silent;
        int         mdelay;
        int         exp_medir;
        int         exp_tx;
        logic [2:0] exp_err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int m0, t0, f0, ml0, tl0, n;
        int exp_tx_log[$];

        tbl[0] = '{3'b000,  3, 3, 6, 3'b000};   // clean round
        tbl[1] = '{3'b010,  3, 3, 4, 3'b010};   // channel 1 never answers
        tbl[2] = '{3'b000, 10, 3, 6, 3'b000};   // echo on the final timeout cycle
        tbl[3] = '{3'b000, 11, 3, 0, 3'b111};   // echo one cycle too late
        tbl[4] = '{3'b101,  3, 3, 2, 3'b101};   // edge channels silent

        #1 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_estado", db_estado, 4'd0);
        chk("rst_medir", medir, 1'b0);
        chk("rst_partida", partida_tx, 1'b0);
        chk("rst_fim", fim, 1'b0);
        chk("rst_zera", zera_sensor, 1'b0);
        chk("rst_ocupado", ocupado, 1'b0);
        chk("rst_sel", {sel_sens, sel_byte}, 3'b000);
        chk("rst_erro", erro_timeout, 3'b000);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_zera", zera_sensor, 1'b1);
        chk("idle_estado", db_estado, 4'd0);

        // Single-round table
        for (int r = 0; r < 5; r++) begin
            silent    = tbl[r].silent;
            med_delay = tbl[r].mdelay;
            continuo  = 1'b0;
            m0 = medir_cnt; t0 = tx_cnt; f0 = fim_cnt;
            ml0 = med_log.size(); tl0 = tx_log.size();
            pulse_jogar();
            chk($sformatf("row%0d_first_medir", r), medir, 1'b1);
            chk($sformatf("row%0d_first_sel", r), sel_sens, 2'd0);
            wait_fim($sformatf("row%0d_fim", r));
            @(negedge clock);
            chk($sformatf("row%0d_fim_width", r), fim, 1'b0);
            chk($sformatf("row%0d_ocupado", r), ocupado, 1'b0);
            @(negedge clock);
            @(negedge clock);
            chk($sformatf("row%0d_medir_cnt", r), medir_cnt - m0, tbl[r].exp_medir);
            chk($sformatf("row%0d_tx_cnt", r), tx_cnt - t0, tbl[r].exp_tx);
            chk($sformatf("row%0d_fim_cnt", r), fim_cnt - f0, 1);
            chk($sformatf("row%0d_erro", r), erro_timeout, tbl[r].exp_err);
            chk($sformatf("row%0d_medlog_len", r), med_log.size() - ml0, 3);
            if (med_log.size() - ml0 == 3)
                for (int i = 0; i < 3; i++)
                    chk($sformatf("row%0d_med_sel%0d", r, i), med_log[ml0 + i], i);
            exp_tx_log = {};
            for (int ch = 0; ch < N; ch++)
                if (!tbl[r].silent[ch] && tbl[r].mdelay <= TO)
                    for (int b = 0; b < B; b++) exp_tx_log.push_back(ch * 16 + b);
            chk($sformatf("row%0d_txlog_len", r), tx_log.size() - tl0, exp_tx_log.size());
            if (tx_log.size() - tl0 == exp_tx_log.size())
                for (int i = 0; i < exp_tx_log.size(); i++)
                    chk($sformatf("row%0d_tx_sel%0d", r, i), tx_log[tl0 + i], exp_tx_log[i]);
        end

        // Continuous mode: parar in INICIAL must not latch; parar in round 2 ends it
        silent = '0; med_delay = 3; continuo = 1'b1;
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        @(negedge clock);
        f0 = fim_cnt;
        pulse_jogar();
        wait_estado(4'd6, "cont_intervalo");
        chk("cont_no_fim_r1", fim_cnt - f0, 0);
        m0 = medir_cnt; t0 = tx_cnt; f0 = fim_cnt;
        n = 0;
        while (medir !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("cont_interval_len", n, IV);
        chk("cont_r2_sel", sel_sens, 2'd0);
        wait_estado(4'd4, "cont_r2_tx");
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        wait_fim("cont_fim");
        repeat (40) @(negedge clock);
        chk("cont_r2_medir", medir_cnt - m0, 3);
        chk("cont_r2_tx", tx_cnt - t0, 6);
        chk("cont_fim_cnt", fim_cnt - f0, 1);
        chk("cont_idle", db_estado, 4'd0);
        continuo = 1'b0;

        // Wrong-channel pronto during channel 0 wait
        silent = 3'b111; t0 = tx_cnt;
        pulse_jogar();
        @(negedge clock);
        n = 0;
        while (db_estado === 4'd2 && n < 50) begin
            n++;
            if (n == 2) pm_extra = 3'b100;
            @(negedge clock);
            pm_extra = '0;
        end
        chk("wrong_ch_dwell", n, TO);
        chk("wrong_ch_erro", erro_timeout, 3'b001);
        chk("wrong_ch_next", db_estado, 4'd5);
        wait_fim("wrong_ch_fim");
        @(negedge clock);
        chk("wrong_ch_erro_all", erro_timeout, 3'b111);
        chk("wrong_ch_no_tx", tx_cnt - t0, 0);

        // Asynchronous reset in the middle of AGUARDA_TX
        silent = 3'b001;
        pulse_jogar();
        wait_estado(4'd4, "arst_tx");
        f0 = fim_cnt;
        #2 reset = 1'b0;
        #1;
        chk("arst_estado", db_estado, 4'd0);
        chk("arst_outs", {medir, partida_tx, fim, zera_sensor, ocupado}, 5'b0);
        chk("arst_sel", {sel_sens, sel_byte}, 3'b000);
        chk("arst_erro", erro_timeout, 3'b000);
        repeat (3) @(negedge clock);
        chk("arst_no_fim", fim_cnt - f0, 0);
        reset = 1'b1;
        silent = '0;
        @(negedge clock);
        pulse_jogar();
        chk("arst_restart_medir", medir, 1'b1);
        chk("arst_restart_sel", sel_sens, 2'd0);
        wait_fim("arst_restart_fim");
        @(negedge clock);
        chk("arst_restart_erro", erro_timeout, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
